approx_adder_share_ctrl: RTL
============================

APPROX_ADDER_SHARE_CTRL -- requirements
Module: approx_adder_share_ctrl

Interface
REQ-001 Parameter ET, default 14, error threshold; absolute error above ET is a violation.
REQ-002 Parameter CNT_W, default 8, width of the violation counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0_valid, req1_valid  input  1 each  requester operand valid.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  4 each  requester operands.
REQ-007 req0_ready, req1_ready  output  1 each  accept strobe for the granted requester.
REQ-008 add_a, add_b  output  4 each  operands driven to the shared external approximate 4+4->5 adder.
REQ-009 add_sum  input  5  combinational sum returned by the shared adder.
REQ-010 rsp_valid  output  1  result valid; rsp_ready  input  1  consumer accept.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_sum  output  5  registered approximate sum.
REQ-013 err_viol  output  1  the current result violates ET; valid while rsp_valid=1.
REQ-014 err_cnt  output  CNT_W  saturating count of violating results.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, ISSUE and RESP.
REQ-016 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally that cycle, latch its operands and id, go to ISSUE; otherwise stay.
REQ-017 Arbitration SHALL be round-robin: on a tie, grant the requester not served last; with a single requester valid, grant it.
REQ-018 reqN_ready SHALL be 1 only in IDLE, only for the granted N, and at most one ready high per cycle.
REQ-019 ISSUE: drive the latched operands on add_a/add_b, register add_sum into rsp_sum at the clock edge, go to RESP; add_a/add_b SHALL be 0 in every other state.
REQ-020 RESP: rsp_valid=1 and rsp_sum, rsp_id, err_viol held stable until rsp_ready=1; on the handshake edge update the last-served pointer to rsp_id and return to IDLE.
REQ-021 Latency: handshake accepted in cycle N gives rsp_valid in cycle N+2; with rsp_ready held high, throughput is one result per 3 cycles.
REQ-022 New requests arriving during ISSUE/RESP SHALL NOT be accepted; requesters hold valid/operands until ready.
REQ-023 Error monitor: exact = a+b (5-bit, no overflow); err = |exact - add_sum| computed in 6-bit signed arithmetic; err_viol = (err > ET), registered in ISSUE alongside rsp_sum.
REQ-024 err_cnt SHALL increment by 1 on each RESP handshake with err_viol=1 and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-025 rsp_valid high with rsp_ready low SHALL stall indefinitely with no output change.

Reset
REQ-026 rst=1 SHALL force state IDLE, last-served pointer to 1 (requester 0 wins the first tie), rsp_valid=0, rsp_sum=0, rsp_id=0, err_viol=0, err_cnt=0, both ready=0, add_a=add_b=0.
REQ-027 rst asserted in ISSUE or RESP SHALL discard the in-flight operation without a response or counter update.
REQ-028 Ready outputs SHALL be 0 in any cycle where rst=1.

Configuration
REQ-029 Macro APPROX_ERR_MON_EN defined: error monitor per REQ-023/REQ-024 compiled in.
REQ-030 Macro APPROX_ERR_MON_EN undefined: no monitor logic; err_viol and err_cnt are constant 0; all other behaviour and timing are unchanged.

Verification
REQ-031 Reset, then req0_valid=1, a=3, b=4, add_sum model returns 7, rsp_ready=1 -> req0_ready in cycle 0, rsp_valid in cycle 2 with rsp_sum=7, rsp_id=0, err_viol=0.
REQ-032 Both valid in the same cycle after reset, held for 4 results -> grant order 0,1,0,1; no two readies in the same cycle.
REQ-033 a=15, b=15, add_sum forced to 0 (err=30>14), monitor enabled -> err_viol=1, err_cnt increments to 1 on the handshake.
REQ-034 a=8, b=7, add_sum forced to 1 (err=14, not >14) -> err_viol=0, err_cnt unchanged.
REQ-035 rsp_ready held 0 for 10 cycles in RESP with req1_valid=1 -> rsp outputs stable, req1_ready stays 0; release -> req1 granted next cycle; rst pulsed during ISSUE -> no rsp_valid, all outputs at reset values.
REQ-036 CNT_W=2 with 5 violating results -> err_cnt saturates at 3; build without APPROX_ERR_MON_EN -> err_viol=err_cnt=0 throughout.

Source files
------------

// File: rtl/approx_adder_share_ctrl.sv
// approx_adder_share_ctrl: round-robin front end that time-shares one external
// approximate 4+4->5 adder between two requesters, one result every 3 cycles.
// Optional error monitor compiled in when APPROX_ERR_MON_EN is defined; without
// it err_viol and err_cnt are tied to zero and timing is identical.

module approx_adder_share_ctrl #(
  parameter int ET    = 14,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic             req1_valid,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  input  logic [4:0]       add_sum,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [4:0]       rsp_sum,
  output logic             err_viol,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic       last_served;
  logic       grant_any;
  logic       grant_id;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       op_id;
  logic       rsp_hs;

  assign rsp_hs = (state == RESP) && rsp_ready;

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_served;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Next-state and per-state outputs; ready is suppressed while in reset.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    add_a      = 4'd0;
    add_b      = 4'd0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any && !rst) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        add_a     = op_a;
        add_b     = op_b;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture on grant, result capture in ISSUE, pointer update on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a        <= 4'd0;
      op_b        <= 4'd0;
      op_id       <= 1'b0;
      rsp_sum     <= 5'd0;
      rsp_id      <= 1'b0;
      last_served <= 1'b1;
    end else begin
      if (state == IDLE && grant_any) begin
        op_a  <= grant_id ? req1_a : req0_a;
        op_b  <= grant_id ? req1_b : req0_b;
        op_id <= grant_id;
      end
      if (state == ISSUE) begin
        rsp_sum <= add_sum;
        rsp_id  <= op_id;
      end
      if (rsp_hs) begin
        last_served <= rsp_id;
      end
    end
  end

`ifdef APPROX_ERR_MON_EN
  localparam logic [31:0] ET_LIM = 32'(ET);

  logic [4:0]        exact_sum;
  logic signed [5:0] err_diff;
  logic [5:0]        err_abs;
  logic              viol_now;

  // Exact reference sum and absolute error of the shared adder's answer.
  always_comb begin
    exact_sum = 5'(op_a) + 5'(op_b);
    err_diff  = $signed({1'b0, exact_sum}) - $signed({1'b0, add_sum});
    err_abs   = err_diff[5] ? $unsigned(-err_diff) : $unsigned(err_diff);
    viol_now  = (32'(err_abs) > ET_LIM);
  end

  // Violation flag travels with rsp_sum; counter saturates at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_viol <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (state == ISSUE) begin
        err_viol <= viol_now;
      end
      if (rsp_hs && err_viol && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end
`else
  // Threshold only matters to the monitor; keep it referenced in this build.
  localparam int unused_et = ET;

  assign err_viol = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule
